// File: rtl/uart_tx_serializer.sv
// UART transmit engine: pops one character from the TX FIFO and serialises it
// as start / data (LSB first) / optional parity / stop bits at a programmable rate.
module uart_tx_serializer #(
  parameter int DATA_WIDTH = 8,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  cfg_en_i,
  input  logic [DIV_WIDTH-1:0]  cfg_div_i,
  input  logic [1:0]            cfg_bits_i,
  input  logic                  cfg_parity_en_i,
  input  logic                  cfg_parity_odd_i,
  input  logic                  cfg_stop2_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic                  tx_o,
  output logic                  busy_o
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [DIV_WIDTH-1:0]  baud_q, baud_d;
  logic [2:0]            bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  par_q, par_d;
  logic [DIV_WIDTH-1:0]  div_q, div_d;
  logic [1:0]            bits_q, bits_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic                  stop2_q, stop2_d;

  logic                  bit_end;
  logic                  last_data;

  // Frame format is held in the *_q copies so register writes mid-frame are harmless.
  assign bit_end   = (baud_q == div_q);
  assign last_data = (bit_q == ({1'b0, bits_q} + 3'd4));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      baud_q    <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      div_q     <= '0;
      bits_q    <= '0;
      par_en_q  <= 1'b0;
      par_odd_q <= 1'b0;
      stop2_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      baud_q    <= baud_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      div_q     <= div_d;
      bits_q    <= bits_d;
      par_en_q  <= par_en_d;
      par_odd_q <= par_odd_d;
      stop2_q   <= stop2_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    par_d      = par_q;
    div_d      = div_q;
    bits_d     = bits_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    stop2_d    = stop2_q;
    tx_ready_o = 1'b0;
    tx_o       = 1'b1;
    busy_o     = 1'b0;

    case (state_q)
      IDLE: begin
        tx_ready_o = cfg_en_i & rstn_i;
        if (cfg_en_i && tx_valid_i) begin
          state_d   = START;
          baud_d    = '0;
          bit_d     = '0;
          par_d     = 1'b0;
          shift_d   = tx_data_i;
          div_d     = cfg_div_i;
          bits_d    = cfg_bits_i;
          par_en_d  = cfg_parity_en_i;
          par_odd_d = cfg_parity_odd_i;
          stop2_d   = cfg_stop2_i;
        end
      end

      START: begin
        tx_o   = 1'b0;
        busy_o = 1'b1;
        if (bit_end) begin
          state_d = DATA;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      // Parity accumulates only the bits actually sent, so unused upper bits never leak in.
      DATA: begin
        tx_o   = shift_q[0];
        busy_o = 1'b1;
        if (bit_end) begin
          baud_d  = '0;
          shift_d = shift_q >> 1;
          par_d   = par_q ^ shift_q[0];
          if (last_data) begin
            bit_d   = '0;
            state_d = par_en_q ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      PARITY: begin
        tx_o   = par_q ^ par_odd_q;
        busy_o = 1'b1;
        if (bit_end) begin
          state_d = STOP;
          baud_d  = '0;
          bit_d   = '0;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      STOP: begin
        tx_o   = 1'b1;
        busy_o = 1'b1;
        if (bit_end) begin
          baud_d = '0;
          if (stop2_q && (bit_q == 3'd0)) begin
            bit_d = 3'd1;
          end else begin
            bit_d   = '0;
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: a frame-level reference model
// predicts the line cycle by cycle; directed cases pin exact waveforms.
module tb_uart_tx_serializer;

  localparam int DW = 8;
  localparam int VW = 16;

  logic          clk_i = 1'b0;
  logic          rstn_i;
  logic          cfg_en_i;
  logic [VW-1:0] cfg_div_i;
  logic [1:0]    cfg_bits_i;
  logic          cfg_parity_en_i;
  logic          cfg_parity_odd_i;
  logic          cfg_stop2_i;
  logic [DW-1:0] tx_data_i;
  logic          tx_valid_i;
  logic          tx_ready_o;
  logic          tx_o;
  logic          busy_o;

  int compared   = 0;
  int mismatched = 0;
  int readyCount = 0;

  logic [7:0] fifoQ[$];
  logic       mq[$];
  logic       txCap[200];
  logic       busyCap[200];

  uart_tx_serializer #(.DATA_WIDTH(DW), .DIV_WIDTH(VW)) dut (
    .clk_i            (clk_i),
    .rstn_i           (rstn_i),
    .cfg_en_i         (cfg_en_i),
    .cfg_div_i        (cfg_div_i),
    .cfg_bits_i       (cfg_bits_i),
    .cfg_parity_en_i  (cfg_parity_en_i),
    .cfg_parity_odd_i (cfg_parity_odd_i),
    .cfg_stop2_i      (cfg_stop2_i),
    .tx_data_i        (tx_data_i),
    .tx_valid_i       (tx_valid_i),
    .tx_ready_o       (tx_ready_o),
    .tx_o             (tx_o),
    .busy_o           (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame as a list of line levels, one entry per bit period.
  function automatic int frameBits(input logic [7:0] d, input logic [1:0] b,
                                   input logic pe, input logic po, input logic s2,
                                   output logic [11:0] vec);
    int   n;
    int   len;
    logic p;
    n   = 5 + int'(b);
    len = 1;
    p   = po;
    vec = '0;
    for (int i = 0; i < n; i++) begin
      vec[len] = d[i];
      p        = p ^ d[i];
      len++;
    end
    if (pe) begin
      vec[len] = p;
      len++;
    end
    vec[len] = 1'b1;
    len++;
    if (s2) begin
      vec[len] = 1'b1;
      len++;
    end
    return len;
  endfunction

  // Reference model: the queue front is the expected line level of the current cycle;
  // an empty queue means idle.
  always @(posedge clk_i or negedge rstn_i) begin
    logic [11:0] vec;
    int          len;
    if (!rstn_i) begin
      mq.delete();
    end else if (mq.size() != 0) begin
      void'(mq.pop_front());
    end else if (cfg_en_i && tx_valid_i) begin
      len = frameBits(tx_data_i, cfg_bits_i, cfg_parity_en_i, cfg_parity_odd_i, cfg_stop2_i, vec);
      for (int i = 0; i < len; i++)
        for (int k = 0; k <= int'(cfg_div_i); k++)
          mq.push_back(vec[i]);
    end
  end

  always @(negedge clk_i) begin
    int eTx;
    int eBusy;
    int eReady;
    eTx    = 1;
    eBusy  = 0;
    eReady = 0;
    if (rstn_i) begin
      if (mq.size() != 0) begin
        eTx   = int'(mq[0]);
        eBusy = 1;
      end else begin
        eReady = int'(cfg_en_i);
      end
    end
    checkOutput("model tx_o", int'(tx_o), eTx);
    checkOutput("model busy_o", int'(busy_o), eBusy);
    checkOutput("model tx_ready_o", int'(tx_ready_o), eReady);
  end

  // FIFO emulation: valid while non-empty, pop on handshake.
  task automatic refreshFifo();
    tx_valid_i = (fifoQ.size() != 0);
    tx_data_i  = (fifoQ.size() != 0) ? fifoQ[0] : 8'h00;
  endtask

  task automatic pushChar(input logic [7:0] d);
    fifoQ.push_back(d);
    refreshFifo();
  endtask

  always @(posedge clk_i) begin
    if (rstn_i && tx_valid_i && tx_ready_o) begin
      void'(fifoQ.pop_front());
      readyCount++;
    end
    #1;
    refreshFifo();
  end

  task automatic applyStimulus(input int div, input int bits, input logic pe,
                               input logic po, input logic s2);
    cfg_div_i        = VW'(div);
    cfg_bits_i       = 2'(bits);
    cfg_parity_en_i  = pe;
    cfg_parity_odd_i = po;
    cfg_stop2_i      = s2;
  endtask

  task automatic captureLine(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk_i);
      txCap[i]   = tx_o;
      busyCap[i] = busy_o;
    end
  endtask

  function automatic int findStart(input int n);
    for (int i = 0; i < n; i++)
      if (busyCap[i]) return i;
    return -1;
  endfunction

  task automatic checkFrame(input string tag, input int n, input int period,
                            input int len, input logic [11:0] pat);
    int s;
    int cnt;
    s = findStart(n);
    checkOutput({tag, " frame started"}, int'(s >= 0), 1);
    if (s >= 0) begin
      for (int i = 0; i < len; i++)
        checkOutput($sformatf("%s bit %0d", tag, i), int'(txCap[s + i*period]), int'(pat[i]));
      cnt = 0;
      for (int i = 0; i < n; i++)
        if (busyCap[i]) cnt++;
      checkOutput({tag, " busy cycles"}, cnt, len*period);
    end
  endtask

  task automatic waitIdle(input int bound);
    int c;
    c = 0;
    while ((fifoQ.size() != 0 || mq.size() != 0) && c < bound) begin
      @(posedge clk_i);
      c++;
    end
    if (c >= bound) checkOutput("idle wait timeout", 0, 1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic waitBusy(input int bound);
    int c;
    c = 0;
    while (!busy_o && c < bound) begin
      @(negedge clk_i);
      c++;
    end
    if (c >= bound) checkOutput("busy wait timeout", 0, 1);
  endtask

  initial begin
    logic [11:0] vec;
    int          len;
    int          s;
    int          cnt;

    rstn_i     = 1'b0;
    cfg_en_i   = 1'b1;
    tx_valid_i = 1'b0;
    tx_data_i  = 8'h00;
    applyStimulus(0, 3, 1'b0, 1'b0, 1'b0);
    #1;
    checkOutput("reset tx_o", int'(tx_o), 1);
    checkOutput("reset busy_o", int'(busy_o), 0);
    checkOutput("reset tx_ready_o", int'(tx_ready_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;

    len = frameBits(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, vec);
    checkOutput("model 8N1 length", len, 10);
    checkOutput("model 8N1 A5", int'(vec[9:0]), int'(10'b1101001010));
    len = frameBits(8'hC1, 2'b10, 1'b1, 1'b0, 1'b1, vec);
    checkOutput("model 7E2 length", len, 11);
    checkOutput("model 7E2 C1", int'(vec[10:0]), int'(11'b11010000010));

    $display("[TB] 8N1 div=3 data A5");
    @(posedge clk_i); #1;
    applyStimulus(3, 3, 1'b0, 1'b0, 1'b0);
    readyCount = 0;
    pushChar(8'hA5);
    captureLine(60);
    checkFrame("A5 8N1", 60, 4, 10, 12'b0011_0100_1010 | 12'b0010_0000_0000);
    checkOutput("A5 ready pulses", readyCount, 1);
    waitIdle(500);

    $display("[TB] 7E2 div=0 data C1");
    applyStimulus(0, 2, 1'b1, 1'b0, 1'b1);
    pushChar(8'hC1);
    captureLine(20);
    checkFrame("C1 7E2", 20, 1, 11, 12'b0110_1000_0010);
    waitIdle(500);

    $display("[TB] 5O1 / 5E1 div=1 data 1F");
    applyStimulus(1, 0, 1'b1, 1'b1, 1'b0);
    pushChar(8'h1F);
    captureLine(30);
    checkFrame("1F 5O1", 30, 2, 8, 12'b0000_1011_1110);
    waitIdle(500);
    applyStimulus(1, 0, 1'b1, 1'b0, 1'b0);
    pushChar(8'h1F);
    captureLine(30);
    checkFrame("1F 5E1", 30, 2, 8, 12'b0000_1111_1110);
    waitIdle(500);

    $display("[TB] back-to-back 55 0F div=2");
    applyStimulus(2, 3, 1'b0, 1'b0, 1'b0);
    readyCount = 0;
    pushChar(8'h55);
    pushChar(8'h0F);
    captureLine(80);
    s = findStart(80);
    checkOutput("b2b frame started", int'(s >= 0), 1);
    if (s >= 0) begin
      checkOutput("b2b last stop busy", int'(busyCap[s+29]), 1);
      checkOutput("b2b gap busy", int'(busyCap[s+30]), 0);
      checkOutput("b2b gap line", int'(txCap[s+30]), 1);
      checkOutput("b2b second start busy", int'(busyCap[s+31]), 1);
      checkOutput("b2b second start line", int'(txCap[s+31]), 0);
      checkOutput("b2b end idle", int'(busyCap[s+61]), 0);
    end
    cnt = 0;
    for (int i = 0; i < 80; i++)
      if (busyCap[i]) cnt++;
    checkOutput("b2b busy cycles", cnt, 60);
    checkOutput("b2b ready pulses", readyCount, 2);
    waitIdle(500);

    $display("[TB] mid-frame config change and disable, data 3C");
    applyStimulus(1, 3, 1'b0, 1'b0, 1'b0);
    pushChar(8'h3C);
    pushChar(8'h99);
    waitBusy(20);
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (busy_o) cnt++;
      if (k == 6) begin
        #1;
        cfg_div_i = 16'd5;
        cfg_en_i  = 1'b0;
      end
      @(negedge clk_i);
    end
    checkOutput("3C busy cycles", cnt, 20);
    for (int k = 0; k < 8; k++) begin
      checkOutput("disabled ready", int'(tx_ready_o), 0);
      checkOutput("disabled line", int'(tx_o), 1);
      @(negedge clk_i);
    end
    #1;
    cfg_en_i = 1'b1;
    waitIdle(1000);

    $display("[TB] asynchronous reset during data bit 3");
    applyStimulus(2, 3, 1'b0, 1'b0, 1'b0);
    pushChar(8'hA5);
    waitBusy(20);
    repeat (13) @(negedge clk_i);
    #1;
    rstn_i = 1'b0;
    #1;
    checkOutput("async reset tx_o", int'(tx_o), 1);
    checkOutput("async reset busy_o", int'(busy_o), 0);
    checkOutput("async reset tx_ready_o", int'(tx_ready_o), 0);
    repeat (3) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
    #1;
    checkOutput("post reset tx_ready_o", int'(tx_ready_o), 1);
    @(posedge clk_i); #1;
    pushChar(8'h5B);
    captureLine(40);
    s = findStart(40);
    checkOutput("post reset frame started", int'(s >= 0), 1);
    if (s >= 0) begin
      for (int i = 0; i < 3; i++)
        checkOutput($sformatf("post reset start cycle %0d", i), int'(txCap[s+i]), 0);
      checkOutput("post reset data bit0", int'(txCap[s+3]), 1);
    end
    waitIdle(500);

    $display("[TB] randomized frames");
    for (int n = 0; n < 30; n++) begin
      applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      pushChar(8'($urandom));
      if ($urandom_range(0, 2) == 0) pushChar(8'($urandom));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 15)) @(posedge clk_i);
        #1;
        applyStimulus($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      waitIdle(2000);
      repeat ($urandom_range(0, 3)) @(posedge clk_i);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
